// File: rtl/req_encoder_8to3_pkg.sv
// Shared definitions for the 8-to-3 request encoder slice.
//   REQ_W   : number of request lines
//   CODE_W  : width of the binary grant code
//   state_t : two-state grant FSM encoding
package enc_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/req_encoder_8to3_if.sv
// Request/grant bus between requesters/consumer and the encoder.
//   req     : request pulses, bit k = line k
//   ack     : consumer accepts the current code
//   code    : binary index of the granted line
//   valid   : code is valid and stable
//   pending : sticky pending vector (status)
// Modports:
//   master : requester/consumer side (drives req, ack)
//   slave  : encoder side (drives code, valid, pending)
interface req_encoder_8to3_if;
  import enc_pkg::*;

  logic [REQ_W-1:0]  req;
  logic              ack;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic [REQ_W-1:0]  pending;

  modport master (
    output req,
    output ack,
    input  code,
    input  valid,
    input  pending
  );

  modport slave (
    input  req,
    input  ack,
    output code,
    output valid,
    output pending
  );

endinterface

// File: rtl/req_encoder_8to3_prio_enc8.sv
// Combinational 8-input priority encoder.
//   in_vec : request vector
//   idx    : index of the winning set bit (0 when in_vec is all zero)
//   any    : at least one bit of in_vec is set
// HIGH_PRI = 1 selects the highest set bit, HIGH_PRI = 0 the lowest.
module prio_enc8
  import enc_pkg::*;
#(
  parameter int HIGH_PRI = 1
) (
  input  logic [REQ_W-1:0]  in_vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  always_comb begin
    idx = '0;
    any = |in_vec;
    // Scan towards the winning end; the last hit overwrites earlier ones.
    if (HIGH_PRI != 0) begin
      for (int i = 0; i < REQ_W; i++) begin
        if (in_vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = REQ_W - 1; i >= 0; i--) begin
        if (in_vec[i]) idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/req_encoder_8to3.sv
// Sequential 8-to-3 request encoder.
// Captures request pulses into sticky pending bits, presents the index of
// the highest-priority pending line with a valid/ack handshake and clears
// that bit once the grant is acknowledged.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/grant bus (slave side): req, ack in; code, valid, pending out
// Parameter HIGH_PRI: 1 = line 7 wins, 0 = line 0 wins.
module req_encoder_8to3
  import enc_pkg::*;
#(
  parameter int HIGH_PRI = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  req_encoder_8to3_if.slave   bus
);

  state_t            state_reg;
  logic [REQ_W-1:0]  pending_reg;
  logic [REQ_W-1:0]  pending_next;
  logic [CODE_W-1:0] code_reg;
  logic              valid_reg;

  logic              ack_accept;
  logic [REQ_W-1:0]  clr_vec;
  logic [CODE_W-1:0] prio_idx;
  logic              prio_any;

  // ack only counts while a grant is being presented.
  assign ack_accept = valid_reg & bus.ack;

  // One-hot decode of the granted code, used to retire exactly that bit.
  genvar gi;
  generate
    for (gi = 0; gi < REQ_W; gi++) begin : g_clr
      assign clr_vec[gi] = ack_accept && (code_reg == CODE_W'(gi));
    end
  endgenerate

  // Clear first, then OR in new requests: a request arriving on the very
  // cycle its bit is retired keeps the bit set.
  assign pending_next = (pending_reg & ~clr_vec) | bus.req;

  prio_enc8 #(
    .HIGH_PRI (HIGH_PRI)
  ) u_prio (
    .in_vec (pending_reg),
    .idx    (prio_idx),
    .any    (prio_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      case (state_reg)
        ST_IDLE: begin
          if (prio_any) begin
            code_reg  <= prio_idx;
            valid_reg <= 1'b1;
            state_reg <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // code is frozen for the whole grant; re-arbitration happens
          // only in the IDLE cycle that follows an ack.
          if (bus.ack) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.code    = code_reg;
  assign bus.valid   = valid_reg;
  assign bus.pending = pending_reg;

endmodule

// File: tb/tb_req_encoder_8to3.sv
module tb_req_encoder_8to3;

  logic clk;
  logic rst_n;

  req_encoder_8to3_if if_hi ();
  req_encoder_8to3_if if_lo ();

  req_encoder_8to3 #(.HIGH_PRI(1)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(if_hi));
  req_encoder_8to3 #(.HIGH_PRI(0)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(if_lo));

  int checks = 0;
  int errors = 0;

  logic [2:0] q_hi[$];
  logic [2:0] q_lo[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0h t=%0t", name, act, $time);
    end
  endtask

  function automatic logic [7:0] dec3to8(input logic [2:0] c);
    return 8'b1 << c;
  endfunction

  // Advance to 1 time unit after the next n rising edges.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: compare each accepted grant against the queue.
  initial begin
    logic [2:0] exp;
    forever begin
      @(negedge clk);
      if (if_hi.valid === 1'b1 && if_hi.ack === 1'b1) begin
        if (q_hi.size() == 0) begin
          chk("hi_unexpected_grant", {29'd0, if_hi.code}, 32'hFFFF_FFFF);
        end else begin
          exp = q_hi.pop_front();
          chk("hi_grant_code", {29'd0, if_hi.code}, {29'd0, exp});
        end
      end
    end
  end

  initial begin
    logic [2:0] exp;
    forever begin
      @(negedge clk);
      if (if_lo.valid === 1'b1 && if_lo.ack === 1'b1) begin
        if (q_lo.size() == 0) begin
          chk("lo_unexpected_grant", {29'd0, if_lo.code}, 32'hFFFF_FFFF);
        end else begin
          exp = q_lo.pop_front();
          chk("lo_grant_code", {29'd0, if_lo.code}, {29'd0, exp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    if_hi.req  = '0;
    if_hi.ack  = 1'b0;
    if_lo.req  = '0;
    if_lo.ack  = 1'b0;

    // Reset state
    tick(2);
    chk("rst_pending", {24'd0, if_hi.pending}, 32'h00);
    chk("rst_valid",   {31'd0, if_hi.valid},   32'h0);
    chk("rst_code",    {29'd0, if_hi.code},    32'h0);
    rst_n = 1'b1;
    tick(1);

    // Single request on line 5
    if_hi.req = 8'h20;
    if_hi.ack = 1'b1;
    q_hi.push_back(3'd5);
    tick(1);
    if_hi.req = 8'h00;
    chk("single_pending_set", {24'd0, if_hi.pending}, 32'h20);
    chk("single_valid_early", {31'd0, if_hi.valid},   32'h0);
    tick(1);
    chk("single_valid",  {31'd0, if_hi.valid}, 32'h1);
    chk("single_code",   {29'd0, if_hi.code},  32'h5);
    chk("single_decode", {24'd0, dec3to8(if_hi.code)}, 32'h20);
    tick(1);
    chk("single_pending_clr", {24'd0, if_hi.pending}, 32'h00);
    chk("single_valid_clr",   {31'd0, if_hi.valid},   32'h0);
    if_hi.ack = 1'b0;

    // All lines at once, both priority directions
    if_hi.req = 8'hFF;
    if_lo.req = 8'hFF;
    if_hi.ack = 1'b1;
    if_lo.ack = 1'b1;
    for (int i = 7; i >= 0; i--) q_hi.push_back(3'(i));
    for (int i = 0; i < 8; i++)  q_lo.push_back(3'(i));
    tick(1);
    if_hi.req = 8'h00;
    if_lo.req = 8'h00;
    chk("all_pending_hi", {24'd0, if_hi.pending}, 32'hFF);
    // First grant after 1 cycle, then one grant per 2 cycles: 8 grants, 16 cycles.
    tick(16);
    chk("all_pending_hi_done", {24'd0, if_hi.pending}, 32'h00);
    chk("all_pending_lo_done", {24'd0, if_lo.pending}, 32'h00);
    chk("all_q_hi_drained", q_hi.size(), 32'd0);
    chk("all_q_lo_drained", q_lo.size(), 32'd0);
    if_hi.ack = 1'b0;
    if_lo.ack = 1'b0;
    tick(1);

    // Hold stability: grant line 1, higher-priority line 7 arrives mid-hold
    if_hi.req = 8'h02;
    tick(1);
    if_hi.req = 8'h00;
    tick(4);
    if_hi.req = 8'h80;
    tick(1);
    if_hi.req = 8'h00;
    tick(5);
    chk("hold_valid",   {31'd0, if_hi.valid},   32'h1);
    chk("hold_code",    {29'd0, if_hi.code},    32'h1);
    chk("hold_pending", {24'd0, if_hi.pending}, 32'h82);
    q_hi.push_back(3'd1);
    q_hi.push_back(3'd7);
    if_hi.ack = 1'b1;
    tick(1);
    chk("hold_after_ack_pending", {24'd0, if_hi.pending}, 32'h80);
    chk("hold_idle_slot",         {31'd0, if_hi.valid},   32'h0);
    tick(1);
    chk("hold_next_code", {29'd0, if_hi.code}, 32'h7);
    tick(1);
    if_hi.ack = 1'b0;
    chk("hold_q_drained", q_hi.size(), 32'd0);
    chk("hold_pending_end", {24'd0, if_hi.pending}, 32'h00);

    // Collision: req[3] on the cycle its grant is acked
    if_hi.req = 8'h08;
    tick(1);
    if_hi.req = 8'h00;
    tick(1);
    chk("coll_code", {29'd0, if_hi.code}, 32'h3);
    q_hi.push_back(3'd3);
    q_hi.push_back(3'd3);
    if_hi.ack = 1'b1;
    if_hi.req = 8'h08;
    tick(1);
    if_hi.req = 8'h00;
    chk("coll_pending_kept", {24'd0, if_hi.pending}, 32'h08);
    chk("coll_idle_slot",    {31'd0, if_hi.valid},   32'h0);
    tick(1);
    chk("coll_regrant_valid", {31'd0, if_hi.valid}, 32'h1);
    tick(1);
    if_hi.ack = 1'b0;
    chk("coll_pending_end", {24'd0, if_hi.pending}, 32'h00);
    chk("coll_q_drained", q_hi.size(), 32'd0);

    // Spurious ack while idle with nothing pending
    if_hi.ack = 1'b1;
    tick(3);
    chk("spur_valid",   {31'd0, if_hi.valid},   32'h0);
    chk("spur_pending", {24'd0, if_hi.pending}, 32'h00);
    chk("spur_code_hold", {29'd0, if_hi.code},  32'h3);
    if_hi.ack = 1'b0;

    // Asynchronous reset mid-handshake
    if_hi.req = 8'hA5;
    tick(1);
    if_hi.req = 8'h00;
    tick(1);
    chk("arst_pre_pending", {24'd0, if_hi.pending}, 32'hA5);
    chk("arst_pre_valid",   {31'd0, if_hi.valid},   32'h1);
    chk("arst_pre_code",    {29'd0, if_hi.code},    32'h7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pending", {24'd0, if_hi.pending}, 32'h00);
    chk("arst_valid",   {31'd0, if_hi.valid},   32'h0);
    chk("arst_code",    {29'd0, if_hi.code},    32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("arst_stays_idle", {31'd0, if_hi.valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
